// File: rtl/sort_result_streamer.sv
// sort_result_streamer: snapshots the sorter result array on load and
// streams it out in index order, flagging the first ordering violation.
module sort_result_streamer #(
  parameter int N  = 10,
  parameter int W  = 32,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  in_data [0:N-1],
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_index,
  output logic          out_last,
  output logic          done,
  output logic          order_err,
  output logic [IW-1:0] err_index
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [W-1:0]  mem [N];
  logic [IW-1:0] idx;
  logic [W-1:0]  prev;

  logic          take;
  logic          xfer;
  logic          at_last;
  logic          pre_last;
  logic          viol;
  logic [W-1:0]  cur;
  logic [W-1:0]  nxt;

  assign at_last  = (idx == IW'(N - 1));
  assign pre_last = (idx == IW'(N - 2));
  assign viol     = (idx != '0) && (cur < prev);

  // busy/valid come straight from the state flop, so they stay registered
  assign busy      = (state == STREAM);
  assign out_valid = (state == STREAM);
  assign out_index = idx;

  // select the element under the pointer and the one after it
  always_comb begin
    cur = '0;
    nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) cur = mem[i];
    end
    for (int i = 1; i < N; i++) begin
      if (idx == IW'(i - 1)) nxt = mem[i];
    end
  end

  // next-state decode: accept load only when idle, leave after last transfer
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    xfer     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          take     = 1'b1;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        xfer = out_ready;
        if (out_ready && at_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // snapshot buffer, written only on an accepted load
  always_ff @(posedge clk) begin
    if (take) begin
      for (int i = 0; i < N; i++) mem[i] <= in_data[i];
    end
  end

  // pointer, output registers and order checker
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      prev      <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      order_err <= 1'b0;
      err_index <= '0;
    end else begin
      done <= 1'b0;
      if (take) begin
        idx       <= '0;
        out_data  <= in_data[0];
        out_last  <= 1'b0;
        order_err <= 1'b0;
        err_index <= '0;
      end else if (xfer) begin
        prev <= cur;
        if (viol) begin
          order_err <= 1'b1;
          if (!order_err) err_index <= idx;
        end
        if (at_last) begin
          done <= 1'b1;
        end else begin
          idx      <= idx + IW'(1);
          out_data <= nxt;
          out_last <= pre_last;
        end
      end
    end
  end

endmodule

// File: doc/sort_result_streamer.md
# sort_result_streamer

Sequential unloader for the parallel sorter output. On a `load` pulse it snapshots the N-element result array, then presents the elements one per handshake on a valid/ready stream in index order (0 first). While streaming, it checks that the sequence is non-decreasing and reports the first violation. It sits between the combinational sorter's `out_data` array and any serial consumer, such as a result logger or a downstream link.

## Interface

**Parameters**
- `N`, default 10: number of array elements; N >= 2.
- `W`, default 32: element width in bits; elements are unsigned.
- `IW`, default 4: index width; must satisfy 2^IW >= N.

**Ports**
- `clk`, input, 1: the only clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `load`, input, 1: capture request; honoured only in IDLE.
- `in_data`, input, W x [0:N-1]: unpacked array from the sorter; sampled only on an accepted `load`.
- `busy`, output, 1: high in STREAM.
- `out_valid`, output, 1: stream element valid.
- `out_ready`, input, 1: consumer ready.
- `out_data`, output, W: current element.
- `out_index`, output, IW: index of the current element.
- `out_last`, output, 1: current element is index N-1.
- `done`, output, 1: one-cycle pulse after the last transfer.
- `order_err`, output, 1: sticky flag; element[k] < element[k-1] was transferred during the current pass.
- `err_index`, output, IW: k of the first violation in the current pass.

## Operation

**States:** IDLE and STREAM, held in a registered FSM.

**IDLE**
- `busy`=0 and `out_valid`=0.
- `load`=1 does all of the following:
  - copies every `in_data[i]` into internal buffer `buf[i]`;
  - clears `order_err` and `err_index`;
  - sets the read pointer `idx`=0;
  - moves the FSM to STREAM.

**STREAM**
- `busy`=1 and `out_valid`=1.
- `out_data`=`buf[idx]`, `out_index`=`idx`, `out_last`=(`idx`==N-1).
- A transfer occurs on `out_valid && out_ready`. On a transfer:
  - If `idx`>0 and `buf[idx]` < `prev` (unsigned), then `order_err`<=1. If `order_err` was 0, also `err_index`<=`idx`.
  - Equal adjacent values are legal.
  - `prev`<=`buf[idx]`.
  - If `idx`==N-1: go to IDLE and pulse `done`. Otherwise `idx`<=`idx`+1.
- `load` is ignored throughout STREAM, including the cycle of the final transfer. `buf` is never rewritten mid-pass.

**Output hold**
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` are stable.
- In IDLE, `out_data`, `out_index` and `out_last` hold their last driven values.
- `order_err` and `err_index` hold until the next accepted `load` or reset.

**Reset:** `rst`=1 at any point, including mid-pass, forces on the next edge:
- FSM to IDLE;
- `busy`, `out_valid`, `out_last`, `done`, `order_err` all 0;
- `out_data`, `out_index`, `err_index` all 0;
- `idx` and `prev` to 0.

No `done` pulse is produced for an aborted pass. `buf` contents are don't-care after reset.

## Timing

- All outputs are registered; there is no combinational path from `out_ready` or `load` to any output.
- `load` accepted at edge t: `out_valid`=1 with element 0 is visible after edge t, i.e. in cycle t+1.
- With `out_ready` held high, elements 0..N-1 appear in N consecutive cycles. Throughput is 1 element/cycle.
- The last transfer occurs at edge u. In cycle u+1, `busy`=0, `out_valid`=0 and `done`=1 for exactly one cycle.
- A `load` in the `done` cycle is accepted. Back-to-back passes therefore have exactly one idle cycle between element N-1 and the next element 0.
- `order_err` and `err_index` update in the cycle after the offending transfer. They are final by the `done` cycle.
- Total pass latency with no backpressure: load edge to done = N+1 cycles.

## Test plan

1. **Reset values.** Reset for 2 cycles -> all outputs 0 and `busy`=0. `load`=0 thereafter -> `out_valid` stays 0.
2. **Sorted pass, no backpressure.**
   - Stimulus: `in_data`={1,2,3,4,5,6,7,8,9,10}, pulse `load`, `out_ready`=1.
   - Required: `out_data` reads 1..10 on 10 consecutive cycles; `out_index` 0..9; `out_last` only with 10; `done` one cycle later; `order_err`=0.
3. **Backpressure.**
   - Stimulus: same data; drop `out_ready` for 3 cycles while element 4 (value 5) is presented.
   - Required: `out_data`=5 and `out_index`=4 held stable; no duplicate or skipped element; `done` arrives 3 cycles later than in scenario 2.
4. **Order violation.**
   - Stimulus: `in_data`={0,3,3,7,2,9,1,10,11,12}.
   - Required: `order_err`=1 and `err_index`=4 after the fifth transfer. `err_index` stays 4 despite the second violation at index 6. The equal pair 3,3 is not flagged.
5. **Load during STREAM and in the done cycle.**
   - Stimulus: pulse `load` with a new array mid-pass, then again in the `done` cycle.
   - Required: the mid-pass load is ignored and the old values complete the pass. The done-cycle load starts a new pass, with element 0 of the new array on the next cycle and `order_err` cleared.
6. **Mid-pass reset.**
   - Stimulus: assert `rst` after 5 transfers.
   - Required: next cycle `out_valid`=0, `busy`=0, no `done` pulse. A subsequent `load` restarts at `out_index`=0.
